bch_syndrome: RTL and testbench

Receive-side front end of the BCH decoder. It takes serial codewords, one bit per accepted cycle with the first transmitted bit first, as produced by the systematic serial encoder. It computes the odd syndromes S1, S3, …, S(2T−1) over GF(2^M) by bit-serial Horner evaluation. On frame completion it presents them with a one-cycle valid strobe and an error flag to the downstream error-locator stage.

---
 rtl/bch_syndrome_if.sv | 34 +++
 rtl/bch_syndrome.sv | 180 ++++++++++++++++++
 tb/tb_bch_syndrome.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/bch_syndrome_if.sv
// -----------------------------------------------------------------------------
// bch_syndrome_if
// Serial code-bit input and syndrome output bundle between the BCH
// receive-side front end and its neighbours.
//   din        : received code bit
//   din_valid  : din accepted this cycle
//   start      : with din_valid, marks bit 0 of a new frame
//   busy       : frame in progress
//   syn_valid  : one-cycle strobe, syndrome/err updated
//   syndrome   : packed odd syndromes, SYN_W = T*M bits
//   err        : OR of all syndrome bits
// master drives the bits (upstream / bench), slave is the syndrome block.
// -----------------------------------------------------------------------------
interface bch_syndrome_if #(
    parameter int SYN_W = 12
);
    logic             din;
    logic             din_valid;
    logic             start;
    logic             busy;
    logic             syn_valid;
    logic [SYN_W-1:0] syndrome;
    logic             err;

    modport master (
        output din, din_valid, start,
        input  busy, syn_valid, syndrome, err
    );

    modport slave (
        input  din, din_valid, start,
        output busy, syn_valid, syndrome, err
    );
endinterface

// File: rtl/bch_syndrome.sv
// -----------------------------------------------------------------------------
// bch_syndrome
// Receive-side BCH front end. Accepts one code bit per valid cycle, first
// transmitted bit = coefficient of x^(N-1), and evaluates the odd syndromes
// S1, S3, ..., S(2T-1) over GF(2^M) by bit-serial Horner evaluation. When the
// last bit of a frame is accepted the syndromes and the error flag are
// registered and announced with a one-cycle syn_valid strobe.
// Ports:
//   clk    : clock, all state on the rising edge
//   reset  : synchronous, active-high
//   bus    : bch_syndrome_if.slave (din, din_valid, start in;
//            busy, syn_valid, syndrome, err out)
// syndrome[M*(i+1)-1 : M*i] = S(2i+1), polynomial basis, bit 0 = alpha^0.
// -----------------------------------------------------------------------------
module bch_syndrome #(
    parameter int N = 15,
    parameter int K = 5,
    parameter int T = 3
) (
    input  logic           clk,
    input  logic           reset,
    bch_syndrome_if.slave  bus
);

    localparam int M  = $clog2(N + 2) - 1;
    localparam int CW = $clog2(N);
    localparam int SW = T * M;

    // Primitive polynomial of GF(2^m) without its leading x^m term.
    // Returns zero for field sizes this codebase does not define.
    function automatic logic [15:0] bch_polynomial(input int m);
        logic [15:0] p;
        case (m)
            2:       p = 16'h0003;   // x^2+x+1
            3:       p = 16'h0003;   // x^3+x+1
            4:       p = 16'h0003;   // x^4+x+1
            5:       p = 16'h0005;   // x^5+x^2+1
            6:       p = 16'h0003;   // x^6+x+1
            7:       p = 16'h0009;   // x^7+x^3+1
            8:       p = 16'h001D;   // x^8+x^4+x^3+x^2+1
            9:       p = 16'h0011;   // x^9+x^4+1
            10:      p = 16'h0009;   // x^10+x^3+1
            default: p = 16'h0000;
        endcase
        return p;
    endfunction

    localparam logic [M-1:0] POLY_LOW = M'(bch_polynomial(M));
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    // Multiply by alpha^j. j is always an elaboration constant at the call
    // sites, so the loop unrolls into a fixed XOR matrix, not a multiplier.
    function automatic logic [M-1:0] mul_alpha_pow(input logic [M-1:0] x, input int j);
        logic [M-1:0] v;
        v = x;
        for (int k = 0; k < j; k++) begin
            v = (v << 1) ^ (v[M-1] ? POLY_LOW : {M{1'b0}});
        end
        return v;
    endfunction

    if (N < 2) begin : g_bad_n
        $error("bch_syndrome: N must be at least 2");
    end
    if (SW > 256) begin : g_bad_width
        $error("bch_syndrome: T*M must not exceed 256");
    end
    if (bch_polynomial(M) == 16'h0000) begin : g_bad_field
        $error("bch_syndrome: no primitive polynomial for this field size");
    end
    if ((K < 1) || (K >= N)) begin : g_bad_k
        $error("bch_syndrome: K must be in 1..N-1");
    end

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic [CW-1:0]   count_r;
    logic [CW-1:0]   count_next_s;
    logic [SW-1:0]   acc_r;
    logic [SW-1:0]   acc_next_s;
    logic [SW-1:0]   horner_s;
    logic [SW-1:0]   load_s;
    logic [SW-1:0]   syndrome_r;
    logic [SW-1:0]   syndrome_next_s;
    logic            err_r;
    logic            err_next_s;
    logic            syn_valid_r;
    logic            syn_valid_next_s;
    logic            busy_r;
    logic            busy_next_s;

    // One Horner step per accumulator (acc_j * alpha^j + din) and the
    // bit-0 load value, both for the bit currently on din.
    always_comb begin
        horner_s = {SW{1'b0}};
        load_s   = {SW{1'b0}};
        for (int i = 0; i < T; i++) begin
            horner_s[i*M +: M] = mul_alpha_pow(acc_r[i*M +: M], 2 * i + 1) ^ M'(bus.din);
            load_s[i*M +: M]   = M'(bus.din);
        end
    end

    // Frame FSM next state plus accumulator, counter and output updates.
    always_comb begin
        state_next_s     = state_r;
        count_next_s     = count_r;
        acc_next_s       = acc_r;
        syndrome_next_s  = syndrome_r;
        err_next_s       = err_r;
        syn_valid_next_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.din_valid && bus.start) begin
                    acc_next_s   = load_s;
                    count_next_s = CW'(1);
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (bus.din_valid && bus.start) begin
                    // A new start silently drops the frame in flight.
                    acc_next_s   = load_s;
                    count_next_s = CW'(1);
                    state_next_s = RUN;
                end else if (bus.din_valid) begin
                    acc_next_s = horner_s;
                    if (count_r == LAST_CNT) begin
                        syndrome_next_s  = horner_s;
                        err_next_s       = |horner_s;
                        syn_valid_next_s = 1'b1;
                        count_next_s     = {CW{1'b0}};
                        state_next_s     = IDLE;
                    end else begin
                        count_next_s = count_r + CW'(1);
                    end
                end else begin
                    state_next_s = RUN;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
        busy_next_s = (state_next_s == RUN);
    end

    // State, datapath and registered outputs; reset overrides all inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            count_r     <= {CW{1'b0}};
            acc_r       <= {SW{1'b0}};
            syndrome_r  <= {SW{1'b0}};
            err_r       <= 1'b0;
            syn_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            count_r     <= count_next_s;
            acc_r       <= acc_next_s;
            syndrome_r  <= syndrome_next_s;
            err_r       <= err_next_s;
            syn_valid_r <= syn_valid_next_s;
            busy_r      <= busy_next_s;
        end
    end

    assign bus.busy      = busy_r;
    assign bus.syn_valid = syn_valid_r;
    assign bus.syndrome  = syndrome_r;
    assign bus.err       = err_r;

endmodule

// File: tb/tb_bch_syndrome.sv
// -----------------------------------------------------------------------------
// tb_bch_syndrome
// Directed and randomised-message bench for bch_syndrome (N=15, K=5, T=3).
// The reference keeps the received word as a plain bit vector and evaluates
// r(alpha^j) as a sum of alpha powers; every cycle the DUT outputs are
// compared with what that model says they must be.
// -----------------------------------------------------------------------------
module tb_bch_syndrome;

    localparam int N  = 15;
    localparam int K  = 5;
    localparam int T  = 3;
    localparam int M  = 4;
    localparam int SW = T * M;
    localparam int Q  = 15;     // multiplicative order of alpha in GF(16)

    logic clk = 1'b0;
    logic reset;
    int   ntotal = 0;
    int   npass  = 0;

    bch_syndrome_if #(.SYN_W(SW)) bus ();

    bch_syndrome #(.N(N), .K(K), .T(T)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            npass++;
        end
    endtask

    // alpha^k in GF(16), x^4 = x + 1
    function automatic logic [M-1:0] gf_pow(input int k);
        int v;
        v = 1;
        for (int i = 0; i < k; i++) begin
            v = v << 1;
            if ((v & 16) != 0) v = v ^ 19;
        end
        return M'(v);
    endfunction

    // Syndromes of a whole received word: S_j = sum over set bits e of alpha^(j*e).
    function automatic logic [SW-1:0] model_syn(input logic [N-1:0] cw);
        logic [SW-1:0] res;
        logic [M-1:0]  s;
        res = '0;
        for (int i = 0; i < T; i++) begin
            s = '0;
            for (int e = 0; e < N; e++) begin
                if (cw[e]) s = s ^ gf_pow(((2 * i + 1) * e) % Q);
            end
            res[i*M +: M] = s;
        end
        return res;
    endfunction

    // Systematic BCH(15,5) encoder, g(x) = x^10+x^8+x^5+x^4+x^2+x+1.
    function automatic logic [N-1:0] bch_enc(input logic [K-1:0] msg);
        logic [N-1:0] rem;
        rem = {msg, 10'b0};
        for (int b = N - 1; b >= N - K; b--) begin
            if (rem[b]) rem = rem ^ (N'(11'h537) << (b - (N - K)));
        end
        return {msg, rem[N-K-1:0]};
    endfunction

    // Reference model: collects the accepted bits of a frame and predicts the
    // registered outputs for the following cycle.
    logic [N-1:0]  m_cw;
    int            m_nbits;
    bit            m_in;
    bit            chk_en = 1'b0;
    logic          exp_busy;
    logic          exp_sv;
    logic [SW-1:0] exp_syn;
    logic          exp_err;

    always @(posedge clk) begin
        if (reset) begin
            m_in     <= 1'b0;
            m_nbits  <= 0;
            m_cw     <= '0;
            exp_busy <= 1'b0;
            exp_sv   <= 1'b0;
            exp_syn  <= '0;
            exp_err  <= 1'b0;
            chk_en   <= 1'b1;
        end else begin
            exp_sv <= 1'b0;
            if (bus.din_valid && bus.start) begin
                m_in     <= 1'b1;
                m_nbits  <= 1;
                m_cw     <= N'(bus.din) << (N - 1);
                exp_busy <= 1'b1;
            end else if (bus.din_valid && m_in) begin
                if (m_nbits == N - 1) begin
                    exp_syn  <= model_syn(m_cw | N'(bus.din));
                    exp_err  <= (model_syn(m_cw | N'(bus.din)) != '0);
                    exp_sv   <= 1'b1;
                    exp_busy <= 1'b0;
                    m_in     <= 1'b0;
                end else begin
                    m_cw[N-1-m_nbits] <= bus.din;
                    m_nbits           <= m_nbits + 1;
                end
            end
        end
    end

    // Per-cycle comparison of all DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(bus.busy), 32'(exp_busy));
            chk("syn_valid", 32'(bus.syn_valid), 32'(exp_sv));
            chk("syndrome", 32'(bus.syndrome), 32'(exp_syn));
            chk("err", 32'(bus.err), 32'(exp_err));
        end
    end

    task automatic cyc(input logic v, input logic s, input logic d);
        bus.din_valid = v;
        bus.start     = s;
        bus.din       = d;
        @(posedge clk);
        #1;
    endtask

    // Sends the first nbits of cw (MSB first), optionally with random gaps.
    task automatic send_frame(input logic [N-1:0] cw, input bit gaps, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            cyc(1'b1, (i == 0), cw[N-1-i]);
        end
    endtask

    initial begin
        logic [N-1:0] cw;
        logic [K-1:0] msg;
        int           p;

        reset         = 1'b1;
        bus.din       = 1'b0;
        bus.din_valid = 1'b0;
        bus.start     = 1'b0;

        // Model pins against hand-computed values.
        chk("model_x14", 32'(model_syn(15'h4000)), 32'h7F9);
        chk("model_x0", 32'(model_syn(15'h0001)), 32'h111);
        chk("enc_g", 32'(bch_enc(5'd1)), 32'h537);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_sv", 32'(bus.syn_valid), 32'd0);
        chk("rst_syn", 32'(bus.syndrome), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        reset = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);

        // All-zero word, continuous valid.
        send_frame(15'h0000, 1'b0, N);
        chk("zero_sv", 32'(bus.syn_valid), 32'd1);
        chk("zero_syn", 32'(bus.syndrome), 32'h000);
        chk("zero_err", 32'(bus.err), 32'd0);

        // Single 1 as the first bit (x^14), back to back.
        send_frame(15'h4000, 1'b0, N);
        chk("x14_sv", 32'(bus.syn_valid), 32'd1);
        chk("x14_syn", 32'(bus.syndrome), 32'h7F9);
        chk("x14_err", 32'(bus.err), 32'd1);

        // Single 1 as the last bit (x^0).
        send_frame(15'h0001, 1'b0, N);
        chk("x0_syn", 32'(bus.syndrome), 32'h111);
        chk("x0_err", 32'(bus.err), 32'd1);

        // Encoded frames with random gaps and 0..3 flips, back to back.
        for (int f = 0; f < 12; f++) begin
            msg = 5'($urandom_range(0, 31));
            cw  = bch_enc(msg);
            chk("enc_clean", 32'(model_syn(cw)), 32'd0);
            p = $urandom_range(0, N - 1);
            for (int e = 0; e < (f % 4); e++) cw[(p + 5 * e) % N] = ~cw[(p + 5 * e) % N];
            send_frame(cw, 1'b1, N);
            chk("frame_sv", 32'(bus.syn_valid), 32'd1);
            chk("frame_err", 32'(bus.err), 32'((f % 4) != 0));
        end
        cyc(1'b0, 1'b0, 1'b0);

        // Abort at bit 7: the restarted frame alone must be reported.
        send_frame(15'h4000, 1'b0, 7);
        cw = bch_enc(5'b10110) ^ 15'h0100;
        send_frame(cw, 1'b0, N);
        chk("abort_sv", 32'(bus.syn_valid), 32'd1);
        chk("abort_syn", 32'(bus.syndrome), 32'(model_syn(cw)));

        // Reset at bit 10, then valid bits without start are ignored.
        send_frame(15'h7FFF, 1'b0, 10);
        reset = 1'b1;
        cyc(1'b1, 1'b0, 1'b1);
        reset = 1'b0;
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_sv", 32'(bus.syn_valid), 32'd0);
        chk("mid_rst_syn", 32'(bus.syndrome), 32'd0);
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 1'($urandom_range(0, 1)));
        chk("ignored_busy", 32'(bus.busy), 32'd0);
        chk("ignored_syn", 32'(bus.syndrome), 32'd0);

        // Recovery frame after reset.
        send_frame(15'h0001, 1'b1, N);
        chk("recover_syn", 32'(bus.syndrome), 32'h111);
        cyc(1'b0, 1'b0, 1'b0);
        repeat (4) cyc(1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
